// File: rtl/ysyx_22050710_ex_ctrl.sv
// EX-stage sequencer: passes single-cycle ops through, parks multi-cycle ops on the
// shared iterative MDU, and latches sticky halt flags for ebreak / invalid / MDU timeout.
module ysyx_22050710_ex_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 127,
  parameter int unsigned CNT_WD      = 7
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_id_valid,
  output logic o_id_ready,
  input  logic i_is_mdu,
  input  logic i_ebreak_sel,
  input  logic i_invalid_inst_sel,
  input  logic i_flush,
  output logic o_mdu_start,
  input  logic i_mdu_done,
  output logic o_mdu_flush,
  output logic o_ex_valid,
  input  logic i_mem_ready,
  output logic o_result_sel,
  output logic o_halt_end,
  output logic o_halt_abort
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MDU  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(MDU_TIMEOUT - 1);
  localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              mdu_start_q, mdu_start_d;
  logic              mdu_flush_q, mdu_flush_d;
  logic              ex_valid_q, ex_valid_d;
  logic              result_sel_q, result_sel_d;
  logic              halt_end_q, halt_end_d;
  logic              halt_abort_q, halt_abort_d;
  logic              id_ready_c;
  logic              accept_c;

  // Ready only when the stage is empty or its held result drains this cycle.
  assign id_ready_c = !i_flush && ((state_q == S_IDLE) || ((state_q == S_OUT) && i_mem_ready));
  assign accept_c   = i_id_valid && id_ready_c;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mdu_start_q  <= 1'b0;
      mdu_flush_q  <= 1'b0;
      ex_valid_q   <= 1'b0;
      result_sel_q <= 1'b0;
      halt_end_q   <= 1'b0;
      halt_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mdu_start_q  <= mdu_start_d;
      mdu_flush_q  <= mdu_flush_d;
      ex_valid_q   <= ex_valid_d;
      result_sel_q <= result_sel_d;
      halt_end_q   <= halt_end_d;
      halt_abort_q <= halt_abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mdu_start_d  = 1'b0;
    mdu_flush_d  = 1'b0;
    result_sel_d = result_sel_q;
    halt_end_d   = halt_end_q;
    halt_abort_d = halt_abort_q;

    case (state_q)
      S_HALT: begin
        state_d = S_HALT;
      end

      // Waiting on the MDU: flush beats done, done beats timeout.
      S_MDU: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WD'(1);
        if (i_flush) begin
          state_d     = S_IDLE;
          mdu_flush_d = 1'b1;
        end else if (i_mdu_done) begin
          state_d      = S_OUT;
          result_sel_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_HALT;
          halt_abort_d = 1'b1;
          mdu_flush_d  = 1'b1;
        end
      end

      default: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (accept_c) begin
          if (i_invalid_inst_sel) begin
            state_d      = S_HALT;
            halt_abort_d = 1'b1;
          end else if (i_ebreak_sel) begin
            state_d    = S_HALT;
            halt_end_d = 1'b1;
          end else if (i_is_mdu) begin
            state_d     = S_MDU;
            cnt_d       = '0;
            mdu_start_d = 1'b1;
          end else begin
            state_d      = S_OUT;
            result_sel_d = 1'b0;
          end
        end else if ((state_q == S_OUT) && i_mem_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase

    ex_valid_d = (state_d == S_OUT);
  end

  assign o_id_ready   = id_ready_c;
  assign o_mdu_start  = mdu_start_q;
  assign o_mdu_flush  = mdu_flush_q;
  assign o_ex_valid   = ex_valid_q;
  assign o_result_sel = result_sel_q;
  assign o_halt_end   = halt_end_q;
  assign o_halt_abort = halt_abort_q;

endmodule
